eth_mac_tx_fifo: RTL and testbench

//  Gigabit Ethernet transmit path: a packet-mode 36-bit word FIFO feeding a GMII byte serializer.

---
 rtl/eth_mac_tx_fifo.sv | 260 ++++++++++++++++++++++++++
 tb/tb_eth_mac_tx_fifo.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mac_tx_fifo.sv
// Gigabit Ethernet transmit path: packet-mode word FIFO with speculative write
// pointer, commit/clear control and overflow discard, feeding a GMII byte
// serializer that adds preamble/SFD, pads short frames, appends the CRC32 FCS
// and holds the inter-frame gap.
module eth_mac_tx_fifo #(
    parameter int ADDR_WIDTH = 9,
    parameter int MIN_FRAME  = 60,
    parameter int IFG_BYTES  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_in,
    input  logic        wr_clr_in,
    input  logic        wr_chk_in,
    input  logic [35:0] wr_d_in,
    output logic        wr_full_out,
    output logic [7:0]  eth_tx_d_out,
    output logic        eth_tx_en_out,
    output logic        eth_tx_err_out
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [15:0] MIN_CNT  = 16'(MIN_FRAME);
    localparam logic [7:0]  IFG_CNT  = 8'(IFG_BYTES);

    typedef logic [ADDR_WIDTH-1:0] ptr_t;
    localparam ptr_t PTR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam ptr_t PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_SFD  = 3'd2,
        S_DATA = 3'd3,
        S_PAD  = 3'd4,
        S_FCS  = 3'd5,
        S_IFG  = 3'd6
    } state_t;

    // Reflected IEEE 802.3 CRC32 update, one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Storage keeps data, end-of-frame and unused-byte count; bit 35 is reserved.
    logic [34:0] mem_r [DEPTH];
    ptr_t        wr_ptr_r, commit_ptr_r, rd_ptr_r;
    logic        full_r, ovf_r;

    logic        wr_ok_s, drop_s, discard_s, ovf_nxt_s;
    ptr_t        wr_ptr_inc_s, wr_ptr_nxt_s, commit_ptr_nxt_s;
    logic        unused_rsvd_s;

    state_t      state_r;
    logic [7:0]  tx_d_r;
    logic        tx_en_r;
    logic [7:0]  cnt_r;
    logic [1:0]  byte_idx_r;
    logic [15:0] data_cnt_r;
    logic [31:0] crc_r;
    logic        last_sent_r;

    logic        rd_empty_s;
    logic [34:0] head_s;
    logic [1:0]  last_idx_s;
    logic [7:0]  head_byte_s, fcs_byte_s;
    logic [31:0] crc_inv_s;

    assign unused_rsvd_s  = wr_d_in[35];
    assign wr_full_out    = full_r;
    assign eth_tx_d_out   = tx_d_r;
    assign eth_tx_en_out  = tx_en_r;
    assign eth_tx_err_out = 1'b0;

    // Next write/commit pointers; a clear, or a commit of a frame that lost a word, rewinds to the last commit.
    always_comb begin
        wr_ok_s      = wr_en_in && !full_r;
        drop_s       = wr_en_in && full_r;
        wr_ptr_inc_s = wr_ptr_r + (wr_ok_s ? PTR_ONE : PTR_ZERO);
        discard_s    = wr_clr_in || (wr_chk_in && (ovf_r || drop_s));
        if (discard_s) begin
            wr_ptr_nxt_s     = commit_ptr_r;
            commit_ptr_nxt_s = commit_ptr_r;
            ovf_nxt_s        = 1'b0;
        end else if (wr_chk_in) begin
            wr_ptr_nxt_s     = wr_ptr_inc_s;
            commit_ptr_nxt_s = wr_ptr_inc_s;
            ovf_nxt_s        = 1'b0;
        end else begin
            wr_ptr_nxt_s     = wr_ptr_inc_s;
            commit_ptr_nxt_s = commit_ptr_r;
            ovf_nxt_s        = ovf_r || drop_s;
        end
    end

    // Word storage; no reset needed since only committed slots are ever read.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_d_in[34:0];
        end
    end

    // Write-side pointer, overflow flag and registered full flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r     <= PTR_ZERO;
            commit_ptr_r <= PTR_ZERO;
            ovf_r        <= 1'b0;
            full_r       <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_nxt_s;
            commit_ptr_r <= commit_ptr_nxt_s;
            ovf_r        <= ovf_nxt_s;
            full_r       <= ((wr_ptr_nxt_s + PTR_ONE) == rd_ptr_r);
        end
    end

    // Head-of-FIFO view and byte selection for the serializer.
    always_comb begin
        rd_empty_s = (rd_ptr_r == commit_ptr_r);
        head_s     = mem_r[rd_ptr_r];
        crc_inv_s  = ~crc_r;
        if (head_s[32]) begin
            last_idx_s = 2'd3 - head_s[34:33];
        end else begin
            last_idx_s = 2'd3;
        end
        case (byte_idx_r)
            2'd0:    begin head_byte_s = head_s[7:0];   fcs_byte_s = crc_inv_s[7:0];   end
            2'd1:    begin head_byte_s = head_s[15:8];  fcs_byte_s = crc_inv_s[15:8];  end
            2'd2:    begin head_byte_s = head_s[23:16]; fcs_byte_s = crc_inv_s[23:16]; end
            default: begin head_byte_s = head_s[31:24]; fcs_byte_s = crc_inv_s[31:24]; end
        endcase
    end

    // Transmit FSM: the registered outputs always carry the byte of the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            tx_d_r      <= 8'h00;
            tx_en_r     <= 1'b0;
            cnt_r       <= 8'd0;
            byte_idx_r  <= 2'd0;
            data_cnt_r  <= 16'd0;
            crc_r       <= CRC_INIT;
            last_sent_r <= 1'b0;
            rd_ptr_r    <= PTR_ZERO;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!rd_empty_s) begin
                        state_r <= S_PRE;
                        tx_en_r <= 1'b1;
                        tx_d_r  <= 8'h55;
                        cnt_r   <= 8'd0;
                    end else begin
                        tx_en_r <= 1'b0;
                        tx_d_r  <= 8'h00;
                    end
                end
                S_PRE: begin
                    tx_en_r <= 1'b1;
                    if (cnt_r == 8'd6) begin
                        state_r     <= S_SFD;
                        tx_d_r      <= 8'hD5;
                        crc_r       <= CRC_INIT;
                        data_cnt_r  <= 16'd0;
                        byte_idx_r  <= 2'd0;
                        last_sent_r <= 1'b0;
                    end else begin
                        tx_d_r <= 8'h55;
                        cnt_r  <= cnt_r + 8'd1;
                    end
                end
                S_SFD, S_DATA: begin
                    tx_en_r <= 1'b1;
                    if (!last_sent_r) begin
                        state_r    <= S_DATA;
                        tx_d_r     <= head_byte_s;
                        crc_r      <= crc32_byte(crc_r, head_byte_s);
                        data_cnt_r <= data_cnt_r + 16'd1;
                        if (byte_idx_r == last_idx_s) begin
                            rd_ptr_r    <= rd_ptr_r + PTR_ONE;
                            byte_idx_r  <= 2'd0;
                            last_sent_r <= head_s[32];
                        end else begin
                            byte_idx_r <= byte_idx_r + 2'd1;
                        end
                    end else if (data_cnt_r < MIN_CNT) begin
                        state_r    <= S_PAD;
                        tx_d_r     <= 8'h00;
                        crc_r      <= crc32_byte(crc_r, 8'h00);
                        data_cnt_r <= data_cnt_r + 16'd1;
                    end else begin
                        state_r    <= S_FCS;
                        tx_d_r     <= crc_inv_s[7:0];
                        byte_idx_r <= 2'd1;
                    end
                end
                S_PAD: begin
                    tx_en_r <= 1'b1;
                    if (data_cnt_r < MIN_CNT) begin
                        tx_d_r     <= 8'h00;
                        crc_r      <= crc32_byte(crc_r, 8'h00);
                        data_cnt_r <= data_cnt_r + 16'd1;
                    end else begin
                        state_r    <= S_FCS;
                        tx_d_r     <= crc_inv_s[7:0];
                        byte_idx_r <= 2'd1;
                    end
                end
                S_FCS: begin
                    if (byte_idx_r == 2'd0) begin
                        state_r <= S_IFG;
                        tx_en_r <= 1'b0;
                        tx_d_r  <= 8'h00;
                        cnt_r   <= 8'd1;
                    end else begin
                        tx_en_r    <= 1'b1;
                        tx_d_r     <= fcs_byte_s;
                        byte_idx_r <= byte_idx_r + 2'd1;
                    end
                end
                S_IFG: begin
                    if (cnt_r == IFG_CNT) begin
                        if (!rd_empty_s) begin
                            state_r <= S_PRE;
                            tx_en_r <= 1'b1;
                            tx_d_r  <= 8'h55;
                            cnt_r   <= 8'd0;
                        end else begin
                            state_r <= S_IDLE;
                            tx_en_r <= 1'b0;
                            tx_d_r  <= 8'h00;
                        end
                    end else begin
                        tx_en_r <= 1'b0;
                        tx_d_r  <= 8'h00;
                        cnt_r   <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    tx_en_r <= 1'b0;
                    tx_d_r  <= 8'h00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_eth_mac_tx_fifo.sv
// Directed testbench for eth_mac_tx_fifo: captures GMII frames and compares
// them against frames built from the written words with a reference CRC32.
module tb_eth_mac_tx_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en_in = 1'b0, wr_clr_in = 1'b0, wr_chk_in = 1'b0;
    logic [35:0] wr_d_in = 36'd0;
    logic        wr_full_out;
    logic [7:0]  eth_tx_d_out;
    logic        eth_tx_en_out, eth_tx_err_out;

    int vec_cnt = 0;
    int err_cnt = 0;

    eth_mac_tx_fifo #(.ADDR_WIDTH(9), .MIN_FRAME(60), .IFG_BYTES(12)) dut (
        .clk(clk), .rst(rst), .wr_en_in(wr_en_in), .wr_clr_in(wr_clr_in),
        .wr_chk_in(wr_chk_in), .wr_d_in(wr_d_in), .wr_full_out(wr_full_out),
        .eth_tx_d_out(eth_tx_d_out), .eth_tx_en_out(eth_tx_en_out),
        .eth_tx_err_out(eth_tx_err_out)
    );

    always #5 clk = ~clk;

    // ---------------- GMII monitor ----------------
    logic [7:0] cur_q[$];
    logic [7:0] frm_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pl_q[$];
    int  frames_done = 0;
    int  en_cycles = 0;
    int  idle_run = 0;
    int  gap_at_start = 0;
    int  last_gap = 0;
    bit  prev_en = 1'b0;
    bit  err_seen = 1'b0;
    bit  idle_d_bad = 1'b0;

    always @(negedge clk) begin
        if (eth_tx_err_out !== 1'b0) err_seen = 1'b1;
        if (eth_tx_en_out === 1'b1) begin
            if (!prev_en) begin
                cur_q.delete();
                gap_at_start = idle_run;
            end
            cur_q.push_back(eth_tx_d_out);
            en_cycles++;
            idle_run = 0;
        end else begin
            if (prev_en) begin
                frm_q = cur_q;
                last_gap = gap_at_start;
                frames_done++;
            end
            if (rst === 1'b1 && eth_tx_d_out !== 8'h00) idle_d_bad = 1'b1;
            idle_run++;
        end
        prev_en = (eth_tx_en_out === 1'b1);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_fcs();
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (pl_q[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ pl_q[k][b];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    task automatic make_exp(input logic [31:0] base, input int nwords, input logic [1:0] unused);
        logic [31:0] w, c;
        int nb;
        pl_q.delete();
        exp_q.delete();
        for (int i = 0; i < nwords; i++) begin
            w  = base + 32'(i);
            nb = (i == nwords - 1) ? 4 - int'(unused) : 4;
            for (int b = 0; b < nb; b++) pl_q.push_back(w[8*b +: 8]);
        end
        while (pl_q.size() < 60) pl_q.push_back(8'h00);
        c = ref_fcs();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (pl_q[k]) exp_q.push_back(pl_q[k]);
        for (int b = 0; b < 4; b++) exp_q.push_back(c[8*b +: 8]);
    endtask

    function automatic int first_diff();
        int n;
        n = (frm_q.size() < exp_q.size()) ? frm_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (frm_q[i] !== exp_q[i]) return i;
        if (frm_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [7:0] got_at(input int i);
        if (i >= 0 && i < frm_q.size()) return frm_q[i];
        return 8'h00;
    endfunction

    function automatic logic [7:0] exp_at(input int i);
        if (i >= 0 && i < exp_q.size()) return exp_q[i];
        return 8'h00;
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive(input logic en, input logic [35:0] d, input logic chk, input logic clr);
        wr_en_in = en; wr_d_in = d; wr_chk_in = chk; wr_clr_in = clr;
        @(posedge clk); #1;
        wr_en_in = 1'b0; wr_chk_in = 1'b0; wr_clr_in = 1'b0;
    endtask

    task automatic write_frame(input logic [31:0] base, input int nwords, input logic [1:0] unused);
        logic last;
        for (int i = 0; i < nwords; i++) begin
            last = (i == nwords - 1);
            drive(1'b1, {1'b0, (last ? unused : 2'b00), last, base + 32'(i)}, last, 1'b0);
        end
    endtask

    task automatic wait_frames(input int target, input int budget, output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (frames_done < target && ok) begin
            if (n >= budget) ok = 1'b0;
            else begin
                @(negedge clk); #1;
                n++;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        vec_cnt++; if (eth_tx_en_out !== 1'b0) begin err_cnt++; $display("FAIL rst_en: got %b expected 0", eth_tx_en_out); end
        vec_cnt++; if (eth_tx_d_out !== 8'h00) begin err_cnt++; $display("FAIL rst_d: got %02h expected 00", eth_tx_d_out); end
        vec_cnt++; if (eth_tx_err_out !== 1'b0) begin err_cnt++; $display("FAIL rst_err: got %b expected 0", eth_tx_err_out); end
        vec_cnt++; if (wr_full_out !== 1'b0) begin err_cnt++; $display("FAIL rst_full: got %b expected 0", wr_full_out); end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_crc_model();
        logic [31:0] c;
        pl_q.delete();
        for (int i = 0; i < 9; i++) pl_q.push_back(8'h31 + 8'(i));
        c = ref_fcs();
        vec_cnt++; if (c !== 32'hCBF4_3926) begin err_cnt++; $display("FAIL crc_model: got %08h expected cbf43926", c); end
    endtask

    task automatic check_frame(input string name, input logic [31:0] base, input int nwords,
                               input logic [1:0] unused, input int exp_len);
        bit ok;
        int idx;
        int start_en;
        write_frame(base, nwords, unused);
        make_exp(base, nwords, unused);
        wait_frames(frames_done + 1, 600, ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL %s_timeout: got no frame expected one", name); end
        vec_cnt++; if (frm_q.size() != exp_len) begin err_cnt++; $display("FAIL %s_len: got %0d expected %0d", name, frm_q.size(), exp_len); end
        idx = first_diff();
        vec_cnt++; if (idx != -1) begin err_cnt++; $display("FAIL %s_bytes: byte %0d got %02h expected %02h", name, idx, got_at(idx), exp_at(idx)); end
        start_en = en_cycles;
        repeat (12) @(negedge clk);
        #1;
        vec_cnt++; if (en_cycles != start_en) begin err_cnt++; $display("FAIL %s_ifg: got %0d en cycles expected 0", name, en_cycles - start_en); end
    endtask

    task automatic test_full_frame();
        check_frame("t1", 32'h0000_0001, 32, 2'd0, 140);
    endtask

    task automatic test_short_frame();
        check_frame("t2", 32'hDDCC_BBAA, 1, 2'd2, 72);
    endtask

    task automatic test_clear();
        int f0, e0;
        f0 = frames_done; e0 = en_cycles;
        for (int i = 0; i < 10; i++) drive(1'b1, {4'b0000, 32'hBAD0_0000 + 32'(i)}, 1'b0, 1'b0);
        drive(1'b0, 36'd0, 1'b0, 1'b1);
        repeat (60) @(negedge clk);
        #1;
        vec_cnt++; if (en_cycles != e0 || frames_done != f0) begin err_cnt++; $display("FAIL t3_clear: got %0d en cycles expected 0", en_cycles - e0); end
        check_frame("t3", 32'h4433_2211, 1, 2'd0, 72);
    endtask

    task automatic test_overflow();
        int e0;
        e0 = en_cycles;
        for (int i = 0; i < 510; i++) drive(1'b1, {4'b0000, 32'(i)}, 1'b0, 1'b0);
        vec_cnt++; if (wr_full_out !== 1'b0) begin err_cnt++; $display("FAIL t4_not_full: got %b expected 0", wr_full_out); end
        drive(1'b1, {4'b0000, 32'd510}, 1'b0, 1'b0);
        vec_cnt++; if (wr_full_out !== 1'b1) begin err_cnt++; $display("FAIL t4_full: got %b expected 1", wr_full_out); end
        for (int i = 0; i < 3; i++) drive(1'b1, {4'b0001, 32'hEEEE_0000 + 32'(i)}, 1'b0, 1'b0);
        vec_cnt++; if (wr_full_out !== 1'b1) begin err_cnt++; $display("FAIL t4_full_hold: got %b expected 1", wr_full_out); end
        drive(1'b0, 36'd0, 1'b1, 1'b0);
        vec_cnt++; if (wr_full_out !== 1'b0) begin err_cnt++; $display("FAIL t4_full_clr: got %b expected 0", wr_full_out); end
        repeat (100) @(negedge clk);
        #1;
        vec_cnt++; if (en_cycles != e0) begin err_cnt++; $display("FAIL t4_no_tx: got %0d en cycles expected 0", en_cycles - e0); end
        check_frame("t4", 32'hCAFE_F00D, 2, 2'd1, 72);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int f0, idx;
        logic [31:0] base;
        f0   = frames_done;
        base = 32'h0A00_0000;
        write_frame(base, 32, 2'd0);
        write_frame(base + 32'd32, 32, 2'd0);
        write_frame(base + 32'd64, 32, 2'd0);
        write_frame(base + 32'd96, 32, 2'd0);
        for (int k = 0; k < 4; k++) begin
            wait_frames(f0 + k + 1, 600, ok);
            vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL t5_timeout%0d: got no frame expected one", k); end
            make_exp(base + 32'(32 * k), 32, 2'd0);
            idx = first_diff();
            vec_cnt++; if (idx != -1) begin err_cnt++; $display("FAIL t5_bytes%0d: byte %0d got %02h expected %02h", k, idx, got_at(idx), exp_at(idx)); end
            if (k > 0) begin
                vec_cnt++; if (last_gap != 12) begin err_cnt++; $display("FAIL t5_gap%0d: got %0d expected 12", k, last_gap); end
            end
        end
        repeat (20) @(negedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int n, e0;
        for (int i = 0; i < 32; i++)
            drive(1'b1, {1'b0, 2'b00, (i == 31), 32'h5000_0000 + 32'(i)}, (i == 31), 1'b0);
        n = 0;
        while (!(eth_tx_en_out === 1'b1 && cur_q.size() >= 20) && n < 400) begin
            @(negedge clk); #1; n++;
        end
        vec_cnt++; if (n >= 400) begin err_cnt++; $display("FAIL t6_start: got no DATA phase expected one"); end
        #2;
        rst = 1'b0;
        #1;
        vec_cnt++; if (eth_tx_en_out !== 1'b0) begin err_cnt++; $display("FAIL t6_en: got %b expected 0", eth_tx_en_out); end
        vec_cnt++; if (eth_tx_d_out !== 8'h00) begin err_cnt++; $display("FAIL t6_d: got %02h expected 00", eth_tx_d_out); end
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        e0 = en_cycles;
        repeat (200) @(negedge clk);
        #1;
        vec_cnt++; if (en_cycles != e0) begin err_cnt++; $display("FAIL t6_empty: got %0d en cycles expected 0", en_cycles - e0); end
        vec_cnt++; if (wr_full_out !== 1'b0) begin err_cnt++; $display("FAIL t6_full: got %b expected 0", wr_full_out); end
        check_frame("t6", 32'h1234_5678, 3, 2'd3, 72);
    endtask

    initial begin
        test_reset();
        test_crc_model();
        test_full_frame();
        test_short_frame();
        test_clear();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        vec_cnt++; if (err_seen) begin err_cnt++; $display("FAIL tx_err: got 1 expected 0"); end
        vec_cnt++; if (idle_d_bad) begin err_cnt++; $display("FAIL idle_d: got nonzero expected 00"); end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
